// File: rtl/memoria_spawn_aste_pkg.sv
// Shared definitions for memoria_spawn_aste: FSM encoding and default geometry/restore values.
package memoria_spawn_aste_pkg;

  localparam int DEF_DATA_W     = 2;
  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_INIT_FIRST = 2;
  localparam int DEF_INIT_REST  = 0;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/memoria_spawn_aste_ram_dp_core.sv
// Storage for memoria_spawn_aste: one synchronous write port, one registered-address
// read port and one asynchronous read port.
module ram_dp_core
  import memoria_spawn_aste_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr_reg;

  // Contents are not reset; a restore sweep defines them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_reg <= '0;
    end else begin
      rd_addr_reg <= rd_addr;
    end
  end

  // Reading through the registered address after the write edge gives write-first behaviour.
  assign rd_data   = mem[rd_addr_reg];
  assign scan_data = mem[scan_addr];

endmodule

// File: rtl/memoria_spawn_aste.sv
// Memory with restore sweep (INIT_FIRST into entry 0, INIT_REST elsewhere) and optional
// scan pointer, compiled only when MEMORIA_SPAWN_ASTE_SCAN_EN is defined.
module memoria_spawn_aste
  import memoria_spawn_aste_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int INIT_FIRST = DEF_INIT_FIRST,
  parameter int INIT_REST  = DEF_INIT_REST
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  input  logic              clear,
  output logic              busy,
  input  logic              scan_en,
  output logic [ADDR_W-1:0] scan_ptr,
  output logic [DATA_W-1:0] scan_q,
  output logic              scan_wrap
);

  localparam int                DEPTH     = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] FIRST_VAL = DATA_W'(INIT_FIRST);
  localparam logic [DATA_W-1:0] REST_VAL  = DATA_W'(INIT_REST);

  state_t            state, state_next;
  logic [ADDR_W-1:0] sweep_ptr, sweep_ptr_next;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] scan_rd_addr;
  logic [DATA_W-1:0] scan_rd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SWEEP;
      sweep_ptr <= '0;
    end else begin
      state     <= state_next;
      sweep_ptr <= sweep_ptr_next;
    end
  end

  // The single RAM write port belongs to the sweep while busy, to the host otherwise.
  always_comb begin
    state_next     = state;
    sweep_ptr_next = sweep_ptr;
    ram_we         = 1'b0;
    ram_waddr      = addr;
    ram_wdata      = data;
    busy           = 1'b0;
    case (state)
      SWEEP: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = sweep_ptr;
        ram_wdata = (sweep_ptr == '0) ? FIRST_VAL : REST_VAL;
        if (clear) begin
          sweep_ptr_next = '0;
        end else if (sweep_ptr == LAST_PTR) begin
          sweep_ptr_next = '0;
          state_next     = IDLE;
        end else begin
          sweep_ptr_next = sweep_ptr + 1'b1;
        end
      end
      IDLE: begin
        ram_we = we;
        if (clear) begin
          state_next     = SWEEP;
          sweep_ptr_next = '0;
        end
      end
      default: begin
        state_next     = SWEEP;
        sweep_ptr_next = '0;
      end
    endcase
  end

  ram_dp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (ram_we),
    .wr_addr   (ram_waddr),
    .wr_data   (ram_wdata),
    .rd_addr   (addr),
    .rd_data   (q),
    .scan_addr (scan_rd_addr),
    .scan_data (scan_rd)
  );

`ifdef MEMORIA_SPAWN_ASTE_SCAN_EN
  logic [ADDR_W-1:0] scan_ptr_r;
  logic              scan_wrap_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_ptr_r  <= '0;
      scan_wrap_r <= 1'b0;
    end else begin
      scan_wrap_r <= 1'b0;
      if (scan_en && !busy) begin
        scan_ptr_r  <= scan_ptr_r + 1'b1;
        scan_wrap_r <= (scan_ptr_r == LAST_PTR);
      end
    end
  end

  assign scan_rd_addr = scan_ptr_r;
  assign scan_ptr     = scan_ptr_r;
  assign scan_q       = scan_rd;
  assign scan_wrap    = scan_wrap_r;
`else
  logic unused_scan;

  assign unused_scan  = scan_en ^ (^scan_rd);
  assign scan_rd_addr = '0;
  assign scan_ptr     = '0;
  assign scan_q       = '0;
  assign scan_wrap    = 1'b0;
`endif

endmodule

// File: tb/tb_memoria_spawn_aste.sv
// Self-checking bench for memoria_spawn_aste (default parameters); scan expectations
// follow whether MEMORIA_SPAWN_ASTE_SCAN_EN is defined.
module tb_memoria_spawn_aste;

`ifdef MEMORIA_SPAWN_ASTE_SCAN_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       we;
  logic [3:0] addr;
  logic [1:0] data;
  logic [1:0] q;
  logic       clear;
  logic       busy;
  logic       scan_en;
  logic [3:0] scan_ptr;
  logic [1:0] scan_q;
  logic       scan_wrap;

  memoria_spawn_aste #(
    .DATA_W     (2),
    .ADDR_W     (4),
    .INIT_FIRST (2),
    .INIT_REST  (0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .we        (we),
    .addr      (addr),
    .data      (data),
    .q         (q),
    .clear     (clear),
    .busy      (busy),
    .scan_en   (scan_en),
    .scan_ptr  (scan_ptr),
    .scan_q    (scan_q),
    .scan_wrap (scan_wrap)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       w;
    logic [3:0] a;
    logic [1:0] d;
    logic [1:0] e;
  } vec_t;

  vec_t       vecs [12];
  logic [1:0] exp_q [$];
  logic [1:0] model [16];
  logic [3:0] sp;
  int         checks;
  int         errors;
  int         wraps;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    for (int i = 0; i < 16; i++) model[i] = (i == 0) ? 2'd2 : 2'd0;
  endtask

  // driver: one host cycle; expected q is queued at drive time and compared after the edge
  task automatic host_op(input logic w, input logic [3:0] a, input logic [1:0] d,
                         input logic [1:0] e, input bit hold, input logic [1:0] hold_e);
    logic [1:0] got_e;
    we   = w;
    addr = a;
    data = d;
    exp_q.push_back(e);
    if (w) model[a] = d;
    #1;
    if (hold) check("q_latency", q, hold_e);
    step();
    we    = 1'b0;
    got_e = exp_q.pop_front();
    check("q", q, got_e);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) host_op(1'b0, 4'(i), 2'd0, (i == 0) ? 2'd2 : 2'd0, 1'b0, 2'd0);
  endtask

  task automatic wait_sweep(input string name);
    int n;
    n = (busy === 1'b1) ? 1 : 0;
    for (int k = 0; k < 40 && busy === 1'b1; k++) begin
      step();
      if (busy === 1'b1) n++;
    end
    check(name, n, 16);
  endtask

  task automatic scan_run(input int n, input logic en, input bit moves, input bit chk_q);
    logic wrap_e;
    for (int k = 0; k < n; k++) begin
      scan_en = en;
      step();
      wrap_e = 1'b0;
      if (en && moves) begin
        wrap_e = (sp == 4'd15);
        sp     = sp + 4'd1;
      end
      if (scan_wrap === 1'b1) wraps++;
      check("scan_ptr", scan_ptr, SCAN_ON ? sp : 4'd0);
      check("scan_wrap", scan_wrap, SCAN_ON ? wrap_e : 1'b0);
      if (chk_q) check("scan_q", scan_q, SCAN_ON ? model[sp] : 2'd0);
    end
    scan_en = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    wraps   = 0;
    sp      = 4'd0;
    reset_n = 1'b0;
    we      = 1'b0;
    addr    = 4'd0;
    data    = 2'd0;
    clear   = 1'b0;
    scan_en = 1'b0;

    vecs[0]  = '{1'b1, 4'd5,  2'd3, 2'd3};
    vecs[1]  = '{1'b0, 4'd5,  2'd0, 2'd3};
    vecs[2]  = '{1'b0, 4'd0,  2'd0, 2'd2};
    vecs[3]  = '{1'b1, 4'd10, 2'd1, 2'd1};
    vecs[4]  = '{1'b0, 4'd6,  2'd0, 2'd0};
    vecs[5]  = '{1'b0, 4'd10, 2'd0, 2'd1};
    vecs[6]  = '{1'b1, 4'd0,  2'd1, 2'd1};
    vecs[7]  = '{1'b0, 4'd15, 2'd0, 2'd0};
    vecs[8]  = '{1'b0, 4'd0,  2'd0, 2'd1};
    vecs[9]  = '{1'b1, 4'd15, 2'd2, 2'd2};
    vecs[10] = '{1'b0, 4'd4,  2'd0, 2'd0};
    vecs[11] = '{1'b0, 4'd5,  2'd0, 2'd3};

    // power-on reset and initial sweep
    step();
    step();
    step();
    check("rst_busy", busy, 1'b1);
    check("rst_scan_ptr", scan_ptr, 4'd0);
    check("rst_scan_wrap", scan_wrap, 1'b0);
    reset_n = 1'b1;
    wait_sweep("init_sweep_len");
    model_init();
    read_all();

    // table of host accesses, including read-during-write
    for (int i = 0; i < 12; i++) begin
      host_op(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].e, i > 0, (i > 0) ? vecs[(i > 0) ? i - 1 : 0].e : 2'd0);
    end

    // scan walk to entry 5, then wrap, then a full 16-step lap from 0
    scan_run(5, 1'b1, 1'b1, 1'b1);
    check("scan_q_at_5", scan_q, SCAN_ON ? 2'd3 : 2'd0);
    scan_run(11, 1'b1, 1'b1, 1'b1);
    scan_run(1, 1'b0, 1'b1, 1'b1);
    wraps = 0;
    scan_run(16, 1'b1, 1'b1, 1'b1);
    scan_run(2, 1'b0, 1'b1, 1'b1);
    check("wrap_count", wraps, SCAN_ON ? 1 : 0);

    // clear together with a write, then writes and scan requests while busy
    clear = 1'b1;
    we    = 1'b1;
    addr  = 4'd3;
    data  = 2'd2;
    #1;
    check("busy_before_clear_edge", busy, 1'b0);
    step();
    clear = 1'b0;
    check("busy_after_clear", busy, 1'b1);
    we      = 1'b1;
    addr    = 4'd7;
    data    = 2'd1;
    scan_en = 1'b1;
    wait_sweep("clear_sweep_len");
    we      = 1'b0;
    scan_en = 1'b0;
    check("scan_ptr_frozen", scan_ptr, SCAN_ON ? sp : 4'd0);
    model_init();
    read_all();

    // clear re-issued at sweep cycle 9 restarts the sweep
    host_op(1'b1, 4'd0, 2'd1, 2'd1, 1'b0, 2'd0);
    host_op(1'b1, 4'd9, 2'd3, 2'd3, 1'b0, 2'd0);
    host_op(1'b1, 4'd12, 2'd2, 2'd2, 1'b0, 2'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 9; k++) step();
    check("busy_mid_sweep", busy, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    wait_sweep("restart_sweep_len");
    model_init();
    read_all();

    // asynchronous reset while idle with scan advanced, then reset mid-sweep
    host_op(1'b1, 4'd0, 2'd1, 2'd1, 1'b0, 2'd0);
    host_op(1'b0, 4'd5, 2'd0, 2'd0, 1'b0, 2'd0);
    scan_run(3, 1'b1, 1'b1, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    sp = 4'd0;
    check("rst_q_ram0", q, 2'd1);
    check("rst_async_busy", busy, 1'b1);
    check("rst_async_scan_ptr", scan_ptr, 4'd0);
    step();
    step();
    reset_n = 1'b1;
    wait_sweep("rst_sweep_len");
    reset_n = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 5; k++) step();
    #3;
    reset_n = 1'b0;
    step();
    check("rst_mid_sweep_busy", busy, 1'b1);
    reset_n = 1'b1;
    wait_sweep("rst_mid_sweep_len");
    model_init();
    read_all();

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memoria_spawn_aste.md
MEMORIA_SPAWN_ASTE -- requirements
Module: memoria_spawn_aste

Interface
REQ-001 Parameter DATA_W, default 2, width of one entry.
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter INIT_FIRST, default 2, value restored into entry 0.
REQ-004 Parameter INIT_REST, default 0, value restored into entries 1..DEPTH-1.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 we  in  1  write enable for the host port.
REQ-008 addr  in  ADDR_W  host read/write address.
REQ-009 data  in  DATA_W  host write data.
REQ-010 q  out  DATA_W  host read data.
REQ-011 clear  in  1  single-cycle pulse; requests a restore of the initial pattern.
REQ-012 busy  out  1  high while a restore sweep is in progress.
REQ-013 scan_en  in  1  advances the scan pointer.
REQ-014 scan_ptr  out  ADDR_W  current scan pointer.
REQ-015 scan_q  out  DATA_W  entry at scan_ptr.
REQ-016 scan_wrap  out  1  single-cycle pulse on pointer wrap.

Function
REQ-017 Host read: addr registered each cycle; q = ram[addr_reg]; one-cycle latency.
REQ-018 Host write: we=1 and busy=0 -> ram[addr] <= data at the edge; we ignored while busy=1.
REQ-019 Read-during-write to the same addr: q shows the new data in the following cycle.
REQ-020 FSM states: SWEEP, IDLE.
REQ-021 SWEEP: writes sweep_ptr entry with INIT_FIRST if sweep_ptr=0, otherwise INIT_REST; increments sweep_ptr; after entry DEPTH-1, moves to IDLE.
REQ-022 A sweep therefore occupies exactly DEPTH cycles, and busy=1 throughout.
REQ-023 IDLE with clear=1 -> SWEEP with sweep_ptr=0; busy rises the next cycle.
REQ-024 clear=1 during SWEEP restarts the sweep at sweep_ptr=0.
REQ-025 Scan: scan_en=1 and busy=0 -> scan_ptr <= scan_ptr+1 modulo DEPTH.
REQ-026 scan_en is ignored while busy=1.
REQ-027 scan_wrap=1 for exactly the cycle after scan_ptr steps from DEPTH-1 to 0; otherwise 0.
REQ-028 scan_q = ram[scan_ptr] combinationally and reflects a host write to that entry from the cycle after the write.
REQ-029 clear and we in the same IDLE cycle: the write is performed, then the sweep overwrites it.

Reset
REQ-030 reset_n low -> FSM=SWEEP, sweep_ptr=0, addr_reg=0, scan_ptr=0, scan_wrap=0.
REQ-031 busy=1 while reset_n is low; q follows ram[0].
REQ-032 After reset_n is released, a full DEPTH-cycle sweep runs; RAM contents are defined only after busy falls.
REQ-033 Reset asserted mid-sweep or mid-scan aborts the operation; a fresh sweep starts from entry 0 on release.

Configuration
REQ-034 Macro MEMORIA_SPAWN_ASTE_SCAN_EN defined -> scan pointer, scan_q and scan_wrap are implemented as specified.
REQ-035 Macro MEMORIA_SPAWN_ASTE_SCAN_EN absent -> scan logic is not compiled; scan_ptr, scan_q and scan_wrap are tied to 0; scan_en is unused; the ports remain.

Structure
REQ-036 The shared package holds the FSM state encoding (SWEEP, IDLE) and the default DATA_W, ADDR_W, INIT_FIRST and INIT_REST constants.
REQ-037 Storage is a sub-module ram_dp_core: one synchronous write port, one registered-address read port and one asynchronous read port.
REQ-038 The FSM, sweep counter and scan counter reside in memoria_spawn_aste.

Verification
REQ-039 Reset pulse, then 16 idle cycles (defaults) -> busy high for 16 cycles after release, then reads of addr 0..15 return 2,0,...,0.
REQ-040 Write addr=5, data=3; next cycle read addr=5 -> q=3 one cycle later; scan_q=3 when scan_ptr=5.
REQ-041 Write while busy=1 (addr=7, data=1) -> entry 7 stays 0 after the sweep.
REQ-042 16 consecutive scan_en pulses from scan_ptr=0 -> scan_ptr returns to 0 and scan_wrap is high for exactly one cycle.
REQ-043 clear at sweep cycle 9 -> busy stays high for 16 further cycles; all entries hold their initial values afterwards.
REQ-044 Build without MEMORIA_SPAWN_ASTE_SCAN_EN and toggle scan_en -> scan_ptr, scan_q and scan_wrap stay 0.
